// File: rtl/rgb2gray_pkg.sv
// ---------------------------------------------------------------------------
// rgb2gray_pkg
// Shared types and constants for the streaming RGB-to-gray converter.
//   state_t         : controller states, one pixel walks GET_R..OUT
//   MODE_AVG/LUMA   : encodings of the mode_i input
//   LUMA_W*         : BT.601 luma weights, they sum to 256
//   LUMA_ROUND/SHIFT: round-half-up then divide by 256
//   AVG_MUL/SHIFT   : 171/512 is a close approximation of 1/3
//   PROD_EXTRA      : extra bits on top of OUT_W for the weighted sums
// ---------------------------------------------------------------------------
package rgb2gray_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_R = 3'd1,
        GET_G = 3'd2,
        GET_B = 3'd3,
        CALC  = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam logic MODE_AVG  = 1'b0;
    localparam logic MODE_LUMA = 1'b1;

    localparam int unsigned LUMA_WR    = 77;
    localparam int unsigned LUMA_WG    = 150;
    localparam int unsigned LUMA_WB    = 29;
    localparam int unsigned LUMA_ROUND = 128;
    localparam int unsigned LUMA_SHIFT = 8;

    localparam int unsigned AVG_MUL    = 171;
    localparam int unsigned AVG_SHIFT  = 9;

    localparam int unsigned PROD_EXTRA = 10;

    // True in the three states where a channel sample may be taken.
    function automatic logic is_capture_state(input state_t s);
        return (s == GET_R) || (s == GET_G) || (s == GET_B);
    endfunction

endpackage

// File: rtl/rgb2gray_weigher.sv
// ---------------------------------------------------------------------------
// rgb2gray_weigher
// Purely combinational: turns one clamped R,G,B triple into a gray value.
// Ports:
//   red, green, blue : clamped channel values, OUT_W bits each
//   mode             : MODE_LUMA selects BT.601 luma, MODE_AVG the average
//   gray             : result, saturated to 2^OUT_W-1
// ---------------------------------------------------------------------------
module rgb2gray_weigher
    import rgb2gray_pkg::*;
#(
    parameter int OUT_W = 8
)(
    input  logic [OUT_W-1:0] red,
    input  logic [OUT_W-1:0] green,
    input  logic [OUT_W-1:0] blue,
    input  logic             mode,
    output logic [OUT_W-1:0] gray
);

    // The weighted sums need at most OUT_W+10 bits (3*255*171 < 2^18 for
    // OUT_W=8), so nothing is truncated before the final shift.
    localparam int PW = OUT_W + int'(PROD_EXTRA);
    localparam logic [PW-1:0] SAT_MAX = PW'((1 << OUT_W) - 1);

    logic [PW-1:0] red_w;
    logic [PW-1:0] green_w;
    logic [PW-1:0] blue_w;
    logic [PW-1:0] luma_sum;
    logic [PW-1:0] avg_prod;
    logic [PW-1:0] luma_q;
    logic [PW-1:0] avg_q;
    logic [PW-1:0] picked;

    // Both modes are computed side by side and the latched mode picks one.
    // Luma cannot exceed full scale, but the average approximation can land
    // a hair above it, so the selected value is saturated in either case.
    always_comb begin
        red_w    = PW'(red);
        green_w  = PW'(green);
        blue_w   = PW'(blue);
        luma_sum = red_w * PW'(LUMA_WR) + green_w * PW'(LUMA_WG)
                 + blue_w * PW'(LUMA_WB) + PW'(LUMA_ROUND);
        avg_prod = (red_w + green_w + blue_w) * PW'(AVG_MUL);
        luma_q   = luma_sum >> LUMA_SHIFT;
        avg_q    = avg_prod >> AVG_SHIFT;
        picked   = (mode == MODE_LUMA) ? luma_q : avg_q;
        gray     = (picked > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : picked[OUT_W-1:0];
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// ---------------------------------------------------------------------------
// rgb2gray_stream
// Handshaked RGB-to-gray converter. A start pulse in IDLE begins a run of
// PIXELS pixels; each pixel arrives as three serial samples R,G,B and leaves
// as one gray value on a valid/ready output that tolerates back-pressure.
// Ports:
//   clk_i, rst_i       : clock (rising edge), asynchronous active-high reset
//   start_i, mode_i    : begin a run; mode (0 average, 1 luma) latched then
//   valid_i, ready_o   : input handshake for RgbColor_i samples
//   RgbColor_i         : one IN_W-bit channel sample
//   valid_o, ready_i   : output handshake for GrayColor_o
//   GrayColor_o        : registered gray result
//   busy_o             : high in every state except IDLE
//   done_o             : one-cycle pulse as the run returns to IDLE
// IN_W is expected to be at least OUT_W.
// ---------------------------------------------------------------------------
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 8,
    parameter int PIXELS = 1
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             valid_i,
    input  logic [IN_W-1:0]  RgbColor_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] GrayColor_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(PIXELS + 1);
    localparam logic [IN_W-1:0]  CLAMP_MAX = IN_W'((1 << OUT_W) - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PIXELS - 1);

    state_t state;
    state_t state_next;

    logic [OUT_W-1:0] red_q;
    logic [OUT_W-1:0] green_q;
    logic [OUT_W-1:0] blue_q;
    logic [OUT_W-1:0] sample_clamped;
    logic [OUT_W-1:0] gray_calc;
    logic [OUT_W-1:0] gray_q;
    logic [CNT_W-1:0] pix_cnt;
    logic             mode_q;
    logic             valid_q;
    logic             done_q;
    logic             accept;
    logic             start_accept;
    logic             out_fire;
    logic             last_pixel;

    assign accept       = valid_i & ready_o;
    assign start_accept = (state == IDLE) & start_i;
    assign out_fire     = valid_q & ready_i;
    assign last_pixel   = (pix_cnt == LAST_IDX);

    assign valid_o     = valid_q;
    assign GrayColor_o = gray_q;
    assign done_o      = done_q;

    // Oversized samples are pinned to full scale rather than wrapped, so a
    // bright 10-bit pixel stays bright after narrowing.
    always_comb begin
        sample_clamped = RgbColor_i[OUT_W-1:0];
        if (RgbColor_i > CLAMP_MAX) begin
            sample_clamped = CLAMP_MAX[OUT_W-1:0];
        end
    end

    rgb2gray_weigher #(
        .OUT_W (OUT_W)
    ) u_weigher (
        .red   (red_q),
        .green (green_q),
        .blue  (blue_q),
        .mode  (mode_q),
        .gray  (gray_calc)
    );

    // State register; reset drops any pixel in flight straight back to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Each channel state waits for its own sample, CALC
    // always lasts one cycle, and OUT waits for the downstream handshake
    // before deciding whether the run has more pixels to go.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_i) state_next = GET_R;
            GET_R: if (accept)  state_next = GET_G;
            GET_G: if (accept)  state_next = GET_B;
            GET_B: if (accept)  state_next = CALC;
            CALC:  state_next = OUT;
            OUT: begin
                if (out_fire) begin
                    state_next = last_pixel ? IDLE : GET_R;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded straight from the state: the input side is only open
    // while a channel is being collected, and busy covers the whole run.
    always_comb begin
        ready_o = is_capture_state(state);
        busy_o  = (state != IDLE);
    end

    // Datapath registers. The mode is frozen at start so mid-run changes on
    // mode_i cannot mix two formulas inside one run. The pixel counter counts
    // completed output handshakes; done is raised on the same edge that
    // returns the controller to IDLE so the two line up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            gray_q  <= '0;
            pix_cnt <= '0;
            mode_q  <= MODE_AVG;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_accept) begin
                mode_q  <= mode_i;
                pix_cnt <= '0;
            end
            if (accept) begin
                case (state)
                    GET_R:   red_q   <= sample_clamped;
                    GET_G:   green_q <= sample_clamped;
                    GET_B:   blue_q  <= sample_clamped;
                    default: ;
                endcase
            end
            if (state == CALC) begin
                gray_q  <= gray_calc;
                valid_q <= 1'b1;
            end
            if (out_fire) begin
                valid_q <= 1'b0;
                if (last_pixel) begin
                    done_q  <= 1'b1;
                    pix_cnt <= '0;
                end else begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// ---------------------------------------------------------------------------
// tb_rgb2gray_stream
// Drives two converters (PIXELS=1 and PIXELS=3) sharing data and handshake
// inputs; only one of them is started at a time. Expected gray values come
// from a plain-arithmetic model of the luma and average formulas.
// ---------------------------------------------------------------------------
module tb_rgb2gray_stream;

    localparam int IN_W  = 10;
    localparam int OUT_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start1 = 1'b0;
    logic            start3 = 1'b0;
    logic            mode = 1'b0;
    logic            valid_in = 1'b0;
    logic            ready_in = 1'b1;
    logic [IN_W-1:0] rgb = '0;
    logic            use3 = 1'b0;

    logic            ready1, valid1, busy1, done1;
    logic            ready3, valid3, busy3, done3;
    logic [7:0]      gray1, gray3;

    wire             ready_s = use3 ? ready3 : ready1;
    wire             valid_s = use3 ? valid3 : valid1;
    wire [7:0]       gray_s  = use3 ? gray3  : gray1;

    int tests_run    = 0;
    int tests_failed = 0;
    int done1_cnt    = 0;
    int done3_cnt    = 0;
    int done3_busy   = 0;

    rgb2gray_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .PIXELS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .mode_i(mode),
        .valid_i(valid_in), .RgbColor_i(rgb), .ready_o(ready1),
        .valid_o(valid1), .ready_i(ready_in), .GrayColor_o(gray1),
        .busy_o(busy1), .done_o(done1)
    );

    rgb2gray_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .PIXELS(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .mode_i(mode),
        .valid_i(valid_in), .RgbColor_i(rgb), .ready_o(ready3),
        .valid_o(valid3), .ready_i(ready_in), .GrayColor_o(gray3),
        .busy_o(busy3), .done_o(done3)
    );

    always #5 clk = ~clk;

    // Count done pulses (and any done seen while still busy) on both devices.
    always @(negedge clk) begin
        if (done1) done1_cnt++;
        if (done3) begin
            done3_cnt++;
            if (busy3) done3_busy++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ref_gray(input int r, input int g, input int b, input bit m);
        int rc, gc, bc, v;
        rc = (r > 255) ? 255 : r;
        gc = (g > 255) ? 255 : g;
        bc = (b > 255) ? 255 : b;
        if (m) v = (77 * rc + 150 * gc + 29 * bc + 128) / 256;
        else begin
            v = ((rc + gc + bc) * 171) / 512;
            if (v > 255) v = 255;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit m);
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        mode = m;
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Presents one sample after 'gap' idle cycles and returns just after the
    // edge that accepted it.
    task automatic send_sample(input int v, input int gap, output bit ok);
        int budget;
        budget   = 40;
        valid_in = 1'b0;
        repeat (gap) begin
            rgb = IN_W'($urandom);
            tick();
        end
        valid_in = 1'b1;
        rgb      = IN_W'(v);
        while (!ready_s && budget > 0) begin
            tick();
            budget--;
        end
        ok = ready_s;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic send_pixel(input int r, input int g, input int b, input int max_gap, output bit ok);
        bit o1, o2, o3;
        send_sample(r, $urandom_range(0, max_gap), o1);
        send_sample(g, $urandom_range(0, max_gap), o2);
        send_sample(b, $urandom_range(0, max_gap), o3);
        ok = o1 & o2 & o3;
    endtask

    task automatic wait_valid(output bit ok);
        int budget;
        budget = 40;
        while (!valid_s && budget > 0) begin
            tick();
            budget--;
        end
        ok = valid_s;
    endtask

    task automatic test_reset();
        tick();
        tests_run++;
        if ({ready1, valid1, busy1, done1, gray1} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut1: got %03h, expected 000", {ready1, valid1, busy1, done1, gray1});
        end
        tests_run++;
        if ({ready3, valid3, busy3, done3, gray3} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut3: got %03h, expected 000", {ready3, valid3, busy3, done3, gray3});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_luma_basic();
        bit ok1, ok2, ok3;
        use3 = 1'b0; ready_in = 1'b1;
        do_start(1'b1);
        tests_run++;
        if (busy1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_after_start: got %0b, expected 1", busy1);
        end
        send_sample(238, 0, ok1);
        send_sample(238, 0, ok2);
        send_sample(238, 0, ok3);
        tests_run++;
        if ({ok1 & ok2 & ok3, valid1} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL calc_cycle_valid: got ok/valid %02b, expected 10", {ok1 & ok2 & ok3, valid1});
        end
        tick();
        tests_run++;
        if ({valid1, gray1} !== {1'b1, 8'd238}) begin
            tests_failed++;
            $display("[TB] FAIL luma_238: got valid %0b gray %0d, expected valid 1 gray 238", valid1, gray1);
        end
        tick();
        tests_run++;
        if ({done1, busy1, valid1} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL done_pulse: got done/busy/valid %03b, expected 100", {done1, busy1, valid1});
        end
        tick();
        tests_run++;
        if (done1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_one_cycle: got %0b, expected 0", done1);
        end
    endtask

    task automatic test_mode_latch();
        bit ok1, ok2, ok3, okv;
        use3 = 1'b0; ready_in = 1'b1;
        do_start(1'b0);
        send_sample(255, 0, ok1);
        mode = 1'b1;
        send_sample(0, 1, ok2);
        send_sample(0, 0, ok3);
        wait_valid(okv);
        tests_run++;
        if ({ok1 & ok2 & ok3 & okv, gray1} !== {1'b1, 8'd85}) begin
            tests_failed++;
            $display("[TB] FAIL average_red: got ok %0b gray %0d, expected ok 1 gray 85", ok1 & ok2 & ok3 & okv, gray1);
        end
        tick();
        do_start(1'b1);
        send_sample(255, 0, ok1);
        mode = 1'b0;
        send_sample(0, 2, ok2);
        send_sample(0, 0, ok3);
        wait_valid(okv);
        tests_run++;
        if ({ok1 & ok2 & ok3 & okv, gray1} !== {1'b1, 8'd77}) begin
            tests_failed++;
            $display("[TB] FAIL luma_red: got ok %0b gray %0d, expected ok 1 gray 77", ok1 & ok2 & ok3 & okv, gray1);
        end
        tick();
    endtask

    task automatic test_clamp();
        bit ok, okv;
        use3 = 1'b0; ready_in = 1'b1;
        for (int m = 0; m < 2; m++) begin
            do_start(m[0]);
            send_pixel(1000, 1000, 1000, 1, ok);
            wait_valid(okv);
            tests_run++;
            if ({ok & okv, gray1} !== {1'b1, 8'd255}) begin
                tests_failed++;
                $display("[TB] FAIL clamp_mode%0d: got ok %0b gray %0d, expected ok 1 gray 255", m, ok & okv, gray1);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        bit ok, okv;
        int r, g, b, exp;
        use3 = 1'b1; ready_in = 1'b0;
        do_start(1'b1);
        r = 300; g = 120; b = 40;
        exp = ref_gray(r, g, b, 1'b1);
        send_pixel(r, g, b, 0, ok);
        wait_valid(okv);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({ok & okv, valid3, gray3, ready3} !== {1'b1, 1'b1, 8'(exp), 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL hold_cycle%0d: got valid %0b gray %0d ready_o %0b, expected valid 1 gray %0d ready_o 0",
                         i, valid3, gray3, ready3, exp);
            end
            valid_in = (i < 3);
            rgb      = IN_W'($urandom);
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        tests_run++;
        if (ready3 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ready_before_handshake: got %0b, expected 0", ready3);
        end
        tick();
        tests_run++;
        if ({ready3, valid3} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL get_r_after_handshake: got ready/valid %02b, expected 10", {ready3, valid3});
        end
        for (int p = 0; p < 2; p++) begin
            r = $urandom_range(0, 1023); g = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
            exp = ref_gray(r, g, b, 1'b1);
            send_pixel(r, g, b, 1, ok);
            wait_valid(okv);
            tests_run++;
            if ({ok & okv, gray3} !== {1'b1, 8'(exp)}) begin
                tests_failed++;
                $display("[TB] FAIL after_hold_pixel%0d: got ok %0b gray %0d, expected ok 1 gray %0d", p, ok & okv, gray3, exp);
            end
            tick();
        end
    endtask

    task automatic test_multi_pixel();
        bit ok, okv, m;
        int r, g, b, exp, base_done, base_busy;
        int exp_q[$];
        use3 = 1'b1; ready_in = 1'b1;
        tick();
        base_done = done3_cnt;
        base_busy = done3_busy;
        m = 1'($urandom);
        do_start(m);
        for (int p = 0; p < 3; p++) begin
            r = $urandom_range(0, 1023); g = $urandom_range(0, 400); b = $urandom_range(0, 255);
            exp_q.push_back(ref_gray(r, g, b, m));
            if (p == 1) begin
                start3 = 1'b1;
                mode   = ~m;
            end
            send_pixel(r, g, b, 3, ok);
            start3 = 1'b0;
            wait_valid(okv);
            exp = exp_q.pop_front();
            tests_run++;
            if ({ok & okv, gray3} !== {1'b1, 8'(exp)}) begin
                tests_failed++;
                $display("[TB] FAIL multi_pixel%0d: got ok %0b gray %0d, expected ok 1 gray %0d", p, ok & okv, gray3, exp);
            end
            tick();
            if (p < 2) begin
                tests_run++;
                if ({done3, busy3} !== 2'b01) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_run_status%0d: got done/busy %02b, expected 01", p, {done3, busy3});
                end
            end
        end
        tests_run++;
        if ({done3, busy3} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL run_end_status: got done/busy %02b, expected 10", {done3, busy3});
        end
        tick();
        tick();
        tests_run++;
        if ({done3_cnt - base_done, done3_busy - base_busy} !== {32'd1, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got %0d pulses (%0d while busy), expected 1 (0)",
                     done3_cnt - base_done, done3_busy - base_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok, okv;
        int base_done, exp;
        use3 = 1'b0; ready_in = 1'b0;
        do_start(1'b1);
        send_sample(200, 0, ok);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({ready1, valid1, busy1, done1, gray1} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_get_g: got %03h, expected 000", {ready1, valid1, busy1, done1, gray1});
        end
        tick();
        rst = 1'b0;
        tick();
        base_done = done1_cnt;
        do_start(1'b1);
        send_pixel(200, 100, 50, 0, ok);
        wait_valid(okv);
        tests_run++;
        if ({ok & okv, gray1} !== {1'b1, 8'(ref_gray(200, 100, 50, 1'b1))}) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_out: got ok %0b gray %0d, expected ok 1 gray %0d",
                     ok & okv, gray1, ref_gray(200, 100, 50, 1'b1));
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({ready1, valid1, busy1, done1, gray1} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_out: got %03h, expected 000", {ready1, valid1, busy1, done1, gray1});
        end
        ready_in = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (done1_cnt !== base_done) begin
            tests_failed++;
            $display("[TB] FAIL no_done_after_reset: got %0d pulses, expected 0", done1_cnt - base_done);
        end
        exp = ref_gray(90, 600, 10, 1'b0);
        do_start(1'b0);
        send_pixel(90, 600, 10, 2, ok);
        wait_valid(okv);
        tests_run++;
        if ({ok & okv, gray1} !== {1'b1, 8'(exp)}) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_convert: got ok %0b gray %0d, expected ok 1 gray %0d", ok & okv, gray1, exp);
        end
        tick();
    endtask

    task automatic test_random_stream();
        bit ok, okv, m;
        int r, g, b, exp, hold;
        use3 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            m = 1'($urandom);
            r = $urandom_range(0, 1023); g = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
            if (n % 4 == 0) begin
                r = $urandom_range(240, 270); g = $urandom_range(240, 270); b = $urandom_range(240, 270);
            end
            exp  = ref_gray(r, g, b, m);
            hold = $urandom_range(0, 3);
            ready_in = (hold == 0);
            do_start(m);
            mode = ~m;
            send_pixel(r, g, b, 2, ok);
            wait_valid(okv);
            repeat (hold) tick();
            tests_run++;
            if ({ok & okv, valid1, gray1} !== {1'b1, 1'b1, 8'(exp)}) begin
                tests_failed++;
                $display("[TB] FAIL random%0d (r%0d g%0d b%0d m%0d): got valid %0b gray %0d, expected valid 1 gray %0d",
                         n, r, g, b, m, valid1, gray1, exp);
            end
            ready_in = 1'b1;
            tick();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_luma_basic();
        test_mode_latch();
        test_clamp();
        test_back_pressure();
        test_multi_pixel();
        test_reset_mid_run();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
